mul_seq: RTL and testbench

Iterative shift-add sequencer for unsigned 32x32 `MULTU`. It owns the HI/LO register pair and replaces the single-cycle multiplier/HiLo path in the EX stage. It accepts a multiply from EX and runs one add/shift step per clock. It stalls the pipeline when a later instruction needs HI/LO or a second multiply arrives while one is in flight.

---
 rtl/mul_seq.sv | 87 ++++++++
 tb/tb_mul_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add unsigned multiplier owning the HI/LO pair, one add/shift step per clock.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_read,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d, sum;
    logic [WIDTH-1:0] mplier_q, mplier_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // acc[WIDTH] is always 0 after a shift, so the add only needs the low bits plus carry out.
    assign sum   = mplier_q[0] ? {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q} : acc_q;
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign stall = busy & (start | hilo_read | mt_hi | mt_lo);
    assign hi    = hi_q;
    assign lo    = lo_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == RUN) begin
            acc_d    = {1'b0, sum[WIDTH:1]};
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                hi_d    = sum[WIDTH:1];
                lo_d    = {sum[0], mplier_q[WIDTH-1:1]};
                state_d = DONE;
            end
        end else begin
            hi_d    = mt_hi ? wdata : hi_q;
            lo_d    = mt_lo ? wdata : lo_q;
            state_d = start ? RUN : IDLE;
            if (start) begin
                mcand_d  = op_a;
                mplier_d = op_b;
                acc_d    = '0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed and random checks of mul_seq against a 64-bit arithmetic product model.
module tb_mul_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        hilo_read = 1'b0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .hilo_read(hilo_read), .mt_hi(mt_hi), .mt_lo(mt_lo), .wdata(wdata),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one multiply from IDLE and checks busy length, done latency and the product.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int n, bc;
        p = 64'(a) * 64'(b);
        start = 1'b1; op_a = a; op_b = b;
        step();
        start = 1'b0;
        n = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            step();
            n++;
            if (busy) bc++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd33);
        chk({tag, "_busy_len"}, 64'(bc), 64'd32);
        chk({tag, "_product"}, {hi, lo}, p);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, hi_keep;
        logic [63:0] p1;
        int n, dc;
        logic stall_ok;

        start = 1'b1; hilo_read = 1'b1; mt_hi = 1'b1; mt_lo = 1'b1; wdata = 32'h1234_5678;
        step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0; start = 1'b0; hilo_read = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        step();

        run_mul("basic", 32'd3, 32'd5);
        run_mul("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul("msb", 32'h8000_0000, 32'd2);
        run_mul("zero", 32'd0, 32'h1234_5678);
        run_mul("ident", 32'd1, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) run_mul("rand", $urandom, $urandom);

        hilo_read = 1'b1;
        #1;
        chk("idle_read_nostall", 64'(stall), 64'd0);
        hilo_read = 1'b0;

        // Hazards during RUN: reads and mthi must stall and mthi must not land.
        a = $urandom; b = $urandom;
        hi_keep = hi;
        start = 1'b1; op_a = a; op_b = b;
        step();
        start = 1'b0;
        step(); step();
        hilo_read = 1'b1;
        #1;
        chk("hz_read_stall", 64'(stall), 64'd1);
        step();
        hilo_read = 1'b0; mt_hi = 1'b1; wdata = 32'hAAAA_5555;
        #1;
        chk("hz_mthi_stall", 64'(stall), 64'd1);
        step();
        mt_hi = 1'b0;
        chk("hz_mthi_ignored", 64'(hi), 64'(hi_keep));
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("hz_product", {hi, lo}, 64'(a) * 64'(b));
        hilo_read = 1'b1;
        #1;
        chk("done_read_nostall", 64'(stall), 64'd0);
        hilo_read = 1'b0;
        step();
        mt_hi = 1'b1; mt_lo = 1'b1; wdata = 32'hAAAA_5555;
        step();
        mt_hi = 1'b0; mt_lo = 1'b0;
        chk("mt_both", {hi, lo}, {32'hAAAA_5555, 32'hAAAA_5555});

        // Queued start held from RUN cycle 5 until accepted leaving DONE.
        a = $urandom; b = $urandom;
        p1 = 64'(a) * 64'(b);
        start = 1'b1; op_a = a; op_b = b;
        step();
        start = 1'b0;
        step(); step(); step(); step();
        start = 1'b1; op_a = 32'd7; op_b = 32'd9;
        stall_ok = 1'b1;
        n = 0;
        #1;
        while (!done && n < 40) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            step();
            n++;
        end
        chk("q_stall_held", 64'(stall_ok), 64'd1);
        chk("q_first_product", {hi, lo}, p1);
        chk("q_done_nostall", 64'(stall), 64'd0);
        step();
        start = 1'b0;
        chk("q_second_busy", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("q_second_latency", 64'(n), 64'd33);
        chk("q_second_product", {hi, lo}, 64'd63);
        step();

        // Reset in the middle of a run aborts it and clears HI/LO.
        start = 1'b1; op_a = $urandom; op_b = $urandom;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dc++;
            step();
        end
        chk("rst_mid_no_done", 64'(dc), 64'd0);
        run_mul("after_rst", $urandom, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
